vec_hazard_ctrl: RTL and testbench

Pipeline hazard and flush controller for the 5-stage vector ASIP (fetch, decode, execute, memory, writeback).
- Tracks destination registers of in-flight instructions in a 3-slot scoreboard (EX, MEM, WB).
- Stalls fetch and decode on read-after-write hazards and inserts bubbles into the decode/execute pipe.
- Kills younger instructions when a PC write resolves in the memory stage.
- Sits beside the pipe registers; drives their hold and clear controls.

---
 rtl/vec_ctrl_pkg.sv | 10 +
 rtl/vec_hazard_ctrl_scoreboard.sv | 43 ++++
 rtl/vec_hazard_ctrl.sv | 67 ++++++
 tb/tb_vec_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_ctrl_pkg.sv
// vec_ctrl_pkg: shared state, scoreboard slot type and limits for the hazard controller
package vec_ctrl_pkg;
  localparam int SEL_W_MAX = 8;
  localparam int FLUSH_MAX = 3;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} hz_state_t;
  typedef struct packed {
    logic                 v;
    logic [SEL_W_MAX-1:0] dest;
  } sb_slot_t;
endpackage

// File: rtl/vec_hazard_ctrl_scoreboard.sv
// hz_scoreboard: EX/MEM/WB destination tracking with two parallel source-hit comparators
module hz_scoreboard
  import vec_ctrl_pkg::*;
#(
  parameter int SEL_W     = 4,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic             wr_en,
  input  logic             flush,
  input  logic [SEL_W-1:0] dest,
  input  logic [SEL_W-1:0] rsel1,
  input  logic [SEL_W-1:0] rsel2,
  output logic             hit1,
  output logic             hit2
);
  sb_slot_t slot_ex_q, slot_ex_d, slot_mem_q, slot_mem_d, slot_wb_q, slot_wb_d;
  function automatic logic match(sb_slot_t s, logic [SEL_W-1:0] r);
    return s.v && (s.dest == SEL_W_MAX'(r));
  endfunction
  always_comb begin
    slot_ex_d  = issue ? sb_slot_t'{v: wr_en, dest: SEL_W_MAX'(dest)} : '0;
    slot_mem_d = flush ? '0 : slot_ex_q;
    slot_wb_d  = slot_mem_q;
    // with a write-before-read register file the WB producer is already visible
    hit1 = match(slot_ex_q, rsel1) || match(slot_mem_q, rsel1) ||
           (WB_BYPASS == 1'b0 && match(slot_wb_q, rsel1));
    hit2 = match(slot_ex_q, rsel2) || match(slot_mem_q, rsel2) ||
           (WB_BYPASS == 1'b0 && match(slot_wb_q, rsel2));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot_ex_q  <= '0;
      slot_mem_q <= '0;
      slot_wb_q  <= '0;
    end else begin
      slot_ex_q  <= slot_ex_d;
      slot_mem_q <= slot_mem_d;
      slot_wb_q  <= slot_wb_d;
    end
endmodule

// File: rtl/vec_hazard_ctrl.sv
// vec_hazard_ctrl: RAW stall and branch flush control for the 5-stage vector pipe
module vec_hazard_ctrl
  import vec_ctrl_pkg::*;
#(
  parameter int SEL_W        = 4,
  parameter bit WB_BYPASS    = 1'b0,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [SEL_W-1:0] dec_rsel1,
  input  logic [SEL_W-1:0] dec_rsel2,
  input  logic             dec_use1,
  input  logic             dec_use2,
  input  logic             dec_wr_en,
  input  logic [SEL_W-1:0] dec_dest,
  input  logic             br_taken,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_dx,
  output logic             flush_fd,
  output logic             flush_xm,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  hz_state_t        state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             hit1, hit2, hazard, issue, in_flush;
  hz_scoreboard #(.SEL_W(SEL_W), .WB_BYPASS(WB_BYPASS)) u_sb (
    .clk(clk), .rst(rst), .issue(issue), .wr_en(dec_wr_en), .flush(br_taken),
    .dest(dec_dest), .rsel1(dec_rsel1), .rsel2(dec_rsel2), .hit1(hit1), .hit2(hit2)
  );
  always_comb begin
    in_flush    = state_q == FLUSH;
    hazard      = dec_valid && !in_flush && ((dec_use1 && hit1) || (dec_use2 && hit2));
    issue       = dec_valid && !hazard && !br_taken && !in_flush;
    // outputs are forced quiet while reset is held, even if br_taken is driven
    flush_fd    = !rst && br_taken;
    flush_xm    = !rst && br_taken;
    bubble_dx   = !rst && (br_taken || in_flush || hazard);
    stall_d     = !rst && !br_taken && hazard;
    stall_f     = stall_d;
    state_d     = br_taken ? FLUSH : in_flush ? (rem_q == 2'd1 ? RUN : FLUSH) : hazard ? STALL : RUN;
    rem_d       = br_taken ? 2'(FLUSH_CYCLES) : in_flush ? rem_q - 2'd1 : rem_q;
    stall_cnt_d = (stall_d && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (br_taken && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_vec_hazard_ctrl.sv
// tb_vec_hazard_ctrl: directed scenario checks of stalls, flushes, reset and counter saturation
module tb_vec_hazard_ctrl;
  import vec_ctrl_pkg::*;
  logic       clk = 0, rst = 0;
  logic       dec_valid = 0, dec_use1 = 0, dec_use2 = 0, dec_wr_en = 0, br_taken = 0;
  logic [3:0] dec_rsel1 = 0, dec_rsel2 = 0, dec_dest = 0;
  logic       stall_f, stall_d, bubble_dx, flush_fd, flush_xm;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;

  vec_hazard_ctrl #(.SEL_W(4), .WB_BYPASS(1'b0), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rsel1(dec_rsel1), .dec_rsel2(dec_rsel2),
    .dec_use1(dec_use1), .dec_use2(dec_use2), .dec_wr_en(dec_wr_en), .dec_dest(dec_dest),
    .br_taken(br_taken), .stall_f(stall_f), .stall_d(stall_d), .bubble_dx(bubble_dx),
    .flush_fd(flush_fd), .flush_xm(flush_xm), .state(state), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [3:0] r1, input logic u1, input logic we, input logic [3:0] d);
    dec_valid = v; dec_rsel1 = r1; dec_use1 = u1; dec_rsel2 = 4'd0; dec_use2 = 1'b0;
    dec_wr_en = we; dec_dest = d;
  endtask

  task automatic do_reset;
    set_dec(0, 0, 0, 0, 0);
    br_taken = 0;
    rst = 1;
    tick; tick;
    rst = 0;
  endtask

  task automatic test_reset;
    set_dec(0, 0, 0, 0, 0);
    rst = 1;
    #2;
    checks++;
    if ({stall_f, stall_d, bubble_dx, flush_fd, flush_xm} !== 5'b0 || state !== 2'd0) begin
      failures++; $display("FAIL reset_outputs got ctrl=%b state=%0d want 0", {stall_f, stall_d, bubble_dx, flush_fd, flush_xm}, state);
    end
    br_taken = 1;
    #1;
    checks++;
    if (flush_fd !== 1'b0 || bubble_dx !== 1'b0) begin
      failures++; $display("FAIL reset_gate_br got flush_fd=%b bubble=%b want 0", flush_fd, bubble_dx);
    end
    br_taken = 0;
    tick; tick;
    rst = 0;
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || dut.u_sb.slot_ex_q.v !== 1'b0) begin
      failures++; $display("FAIL reset_state got stall_cnt=%0d flush_cnt=%0d ex_v=%b want 0", stall_cnt, flush_cnt, dut.u_sb.slot_ex_q.v);
    end
  endtask

  task automatic test_raw_stall;
    do_reset;
    set_dec(1, 0, 0, 1, 4'd3);
    #1;
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL raw_producer got stall_d=%b want 0", stall_d); end
    tick;
    set_dec(1, 4'd3, 1, 1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({stall_f, stall_d, bubble_dx, flush_fd} !== 4'b1110) begin
        failures++; $display("FAIL raw_stall_%0d got f/d/bub/fl=%b want 1110", i, {stall_f, stall_d, bubble_dx, flush_fd});
      end
      tick;
      checks++;
      if (state !== 2'd1) begin failures++; $display("FAIL raw_state_%0d got %0d want 1", i, state); end
    end
    #1;
    checks++;
    if (stall_d !== 1'b0 || bubble_dx !== 1'b0) begin
      failures++; $display("FAIL raw_release got stall_d=%b bubble=%b want 0", stall_d, bubble_dx);
    end
    tick;
    set_dec(0, 0, 0, 0, 0);
    checks++;
    if (dut.u_sb.slot_ex_q !== sb_slot_t'{v: 1'b1, dest: 8'd7} || stall_cnt !== 4'd3 || state !== 2'd0) begin
      failures++; $display("FAIL raw_issue got ex=%h stall_cnt=%0d state=%0d want 107 3 0", dut.u_sb.slot_ex_q, stall_cnt, state);
    end
  endtask

  task automatic test_no_use;
    do_reset;
    set_dec(1, 0, 0, 1, 4'd3);
    tick;
    set_dec(1, 4'd3, 0, 1, 4'd9);
    #1;
    checks++;
    if (stall_d !== 1'b0 || dut.u_sb.slot_ex_q !== sb_slot_t'{v: 1'b1, dest: 8'd3}) begin
      failures++; $display("FAIL nouse_noslot got stall_d=%b ex=%h want 0 103", stall_d, dut.u_sb.slot_ex_q);
    end
    tick;
    set_dec(0, 0, 0, 0, 0);
    checks++;
    if (dut.u_sb.slot_ex_q !== sb_slot_t'{v: 1'b1, dest: 8'd9} || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL nouse_issue got ex=%h stall_cnt=%0d want 109 0", dut.u_sb.slot_ex_q, stall_cnt);
    end
  endtask

  task automatic test_flush;
    do_reset;
    br_taken = 1;
    #1;
    checks++;
    if ({flush_fd, bubble_dx, flush_xm, stall_f, stall_d} !== 5'b11100) begin
      failures++; $display("FAIL flush_pulse got %b want 11100", {flush_fd, bubble_dx, flush_xm, stall_f, stall_d});
    end
    tick;
    br_taken = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (state !== 2'd2 || {flush_fd, bubble_dx, flush_xm, stall_d} !== 4'b0100) begin
        failures++; $display("FAIL flush_bubble_%0d got state=%0d ctrl=%b want 2 0100", i, state, {flush_fd, bubble_dx, flush_xm, stall_d});
      end
      tick;
    end
    checks++;
    if (state !== 2'd0 || bubble_dx !== 1'b0 || flush_cnt !== 4'd1) begin
      failures++; $display("FAIL flush_end got state=%0d bubble=%b flush_cnt=%0d want 0 0 1", state, bubble_dx, flush_cnt);
    end
  endtask

  task automatic test_br_during_stall;
    do_reset;
    set_dec(1, 0, 0, 1, 4'd5);
    tick;
    set_dec(1, 4'd5, 1, 1, 4'd6);
    #1;
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL brst_pre got stall_d=%b want 1", stall_d); end
    br_taken = 1;
    #1;
    checks++;
    if (stall_d !== 1'b0 || stall_f !== 1'b0 || flush_fd !== 1'b1 || flush_xm !== 1'b1) begin
      failures++; $display("FAIL brst_win got stall=%b%b flush=%b%b want 00 11", stall_f, stall_d, flush_fd, flush_xm);
    end
    tick;
    br_taken = 0;
    checks++;
    if (dut.u_sb.slot_mem_q.v !== 1'b0 || dut.u_sb.slot_ex_q.v !== 1'b0 || state !== 2'd2) begin
      failures++; $display("FAIL brst_clear got mem_v=%b ex_v=%b state=%0d want 0 0 2", dut.u_sb.slot_mem_q.v, dut.u_sb.slot_ex_q.v, state);
    end
    tick; tick;
    set_dec(0, 0, 0, 0, 0);
    checks++;
    if (dut.u_sb.slot_ex_q.v !== 1'b0 || stall_cnt !== 4'd0 || state !== 2'd0) begin
      failures++; $display("FAIL brst_discard got ex_v=%b stall_cnt=%0d state=%0d want 0 0 0", dut.u_sb.slot_ex_q.v, stall_cnt, state);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    set_dec(1, 0, 0, 1, 4'd3);
    tick;
    set_dec(1, 4'd3, 1, 1, 4'd7);
    #1;
    checks++;
    if (stall_d !== 1'b1) begin failures++; $display("FAIL arst_pre got stall_d=%b want 1", stall_d); end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({stall_f, stall_d, bubble_dx, flush_fd, flush_xm} !== 5'b0 || state !== 2'd0 || dut.u_sb.slot_ex_q.v !== 1'b0) begin
      failures++; $display("FAIL arst_now got ctrl=%b state=%0d ex_v=%b want 0", {stall_f, stall_d, bubble_dx, flush_fd, flush_xm}, state, dut.u_sb.slot_ex_q.v);
    end
    tick;
    rst = 0;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin failures++; $display("FAIL arst_after got stall_d=%b want 0", stall_d); end
    tick;
    set_dec(0, 0, 0, 0, 0);
    checks++;
    if (dut.u_sb.slot_ex_q !== sb_slot_t'{v: 1'b1, dest: 8'd7}) begin
      failures++; $display("FAIL arst_issue got ex=%h want 107", dut.u_sb.slot_ex_q);
    end
  endtask

  task automatic test_saturate;
    do_reset;
    for (int k = 1; k <= 6; k++) begin
      set_dec(1, 0, 0, 1, 4'd3);
      tick;
      set_dec(1, 4'd3, 1, 0, 4'd0);
      tick; tick; tick; tick;
      if (k >= 4) begin
        checks++;
        if (stall_cnt !== ((k == 4) ? 4'd12 : 4'd15)) begin
          failures++; $display("FAIL sat_%0d got stall_cnt=%0d want %0d", k, stall_cnt, (k == 4) ? 12 : 15);
        end
      end
    end
    set_dec(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_raw_stall;
    test_no_use;
    test_flush;
    test_br_during_stall;
    test_async_reset;
    test_saturate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
